// File: rtl/servo_angle_ctrl.sv
// Multi-channel servo angle generator: rate-accumulated ramp/sweep per channel, key toggles direction.
// Latency: a tick updates the angle one cycle after the accumulator MSB sets; oKeyEvt fires 2+DEB_CYCLES+1 cycles after a stable press.
// Backpressure: none; free-running, outputs are always valid for the downstream PWM generators.
//
// Ports:
//   Clk, Rst_n   - clock, asynchronous active-low reset
//   iKey         - raw push-button (asynchronous, active-high)
//   iSel         - channel whose direction an accepted key press toggles
//   iRate        - accumulator increment per cycle (0 = no motion)
//   iMode        - 0 hold, 1 ramp to limit, 2 continuous sweep, 3 hold
//   oAngle       - packed per-channel angles, channel n at [n*ANGLE_W +: ANGLE_W]
//   oDir         - per-channel direction (1 = increasing)
//   oAtLimit     - channel sits at the limit it is heading toward
//   oKeyEvt      - one-cycle pulse per accepted key press
module servo_angle_ctrl #(
    parameter int NUM_CH     = 4,
    parameter int ANGLE_W    = 8,
    parameter int MIN_ANGLE  = 0,
    parameter int MAX_ANGLE  = 180,
    parameter int INIT_ANGLE = 60,
    parameter int STEP       = 1,
    parameter int ACC_W      = 22,
    parameter int RATE_W     = 4,
    parameter int DEB_CYCLES = 250000,
    localparam int SEL_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                      Clk,
    input  logic                      Rst_n,
    input  logic                      iKey,
    input  logic [SEL_W-1:0]          iSel,
    input  logic [RATE_W-1:0]         iRate,
    input  logic [1:0]                iMode,
    output logic [NUM_CH*ANGLE_W-1:0] oAngle,
    output logic [NUM_CH-1:0]         oDir,
    output logic [NUM_CH-1:0]         oAtLimit,
    output logic                      oKeyEvt
);

    localparam int CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

    localparam logic [ANGLE_W-1:0] MIN_A  = ANGLE_W'(MIN_ANGLE);
    localparam logic [ANGLE_W-1:0] MAX_A  = ANGLE_W'(MAX_ANGLE);
    localparam logic [ANGLE_W-1:0] INIT_A = ANGLE_W'(INIT_ANGLE);
    localparam logic [ANGLE_W-1:0] STEP_A = ANGLE_W'(STEP);
    // One extra bit so that angle+STEP and MIN+STEP never wrap.
    localparam logic [ANGLE_W:0]   MAX_X  = (ANGLE_W+1)'(MAX_ANGLE);
    localparam logic [ANGLE_W:0]   STEP_X = (ANGLE_W+1)'(STEP);
    localparam logic [ANGLE_W:0]   LO_THR = (ANGLE_W+1)'(MIN_ANGLE) + STEP_X;

    // ------------------------------------------------------------------
    // Key path: 2-FF synchroniser, consecutive-cycle debounce, rise detect
    // ------------------------------------------------------------------
    logic             sync1_q, sync2_q;
    logic             deb_q, deb_d;
    logic             deb_dly_q;
    logic             evt_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        deb_d = deb_q;
        cnt_d = '0;
        if (sync2_q != deb_q) begin
            if (cnt_q == CNT_LAST) begin
                deb_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            deb_q     <= 1'b0;
            deb_dly_q <= 1'b0;
            cnt_q     <= '0;
            evt_q     <= 1'b0;
        end else begin
            sync1_q   <= iKey;
            sync2_q   <= sync1_q;
            deb_q     <= deb_d;
            deb_dly_q <= deb_q;
            cnt_q     <= cnt_d;
            evt_q     <= deb_q & ~deb_dly_q;
        end
    end

    assign oKeyEvt = evt_q;

    // ------------------------------------------------------------------
    // Mode decode
    // ------------------------------------------------------------------
    logic run, ramp;
    assign ramp = (iMode == 2'd1);
    assign run  = (iMode == 2'd1) || (iMode == 2'd2);

    // ------------------------------------------------------------------
    // Per-channel accumulator, angle and direction
    // ------------------------------------------------------------------
    for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
        logic [ANGLE_W-1:0] angle_q, angle_d;
        logic [ACC_W-1:0]   acc_q, acc_d;
        logic               dir_q, dir_d;
        logic [ANGLE_W:0]   up_x;
        logic               at_lim;
        logic               tick;
        logic               toggle;
        logic               rev;

        assign up_x   = {1'b0, angle_q} + STEP_X;
        assign at_lim = dir_q ? (angle_q == MAX_A) : (angle_q == MIN_A);
        assign tick   = run & acc_q[ACC_W-1];
        // An out-of-range iSel never matches any channel index, so it is ignored.
        assign toggle = evt_q & (iSel == SEL_W'(n));

        always_comb begin
            angle_d = angle_q;
            acc_d   = acc_q;
            rev     = 1'b0;
            if (run) begin
                if (ramp && at_lim) begin
                    acc_d = '0;
                end else if (tick) begin
                    acc_d = '0;
                    if (at_lim) begin
                        // Only SWEEP reaches here at a limit: reverse instead of stepping.
                        rev = 1'b1;
                    end else if (dir_q) begin
                        angle_d = (up_x > MAX_X) ? MAX_A : up_x[ANGLE_W-1:0];
                    end else begin
                        angle_d = ({1'b0, angle_q} < LO_THR) ? MIN_A : (angle_q - STEP_A);
                    end
                end else begin
                    acc_d = acc_q + ACC_W'(iRate);
                end
            end
            // A key toggle coinciding with a sweep reversal yields one inversion.
            dir_d = dir_q ^ (toggle | rev);
        end

        always_ff @(posedge Clk or negedge Rst_n) begin
            if (!Rst_n) begin
                angle_q <= INIT_A;
                acc_q   <= '0;
                dir_q   <= 1'b0;
            end else begin
                angle_q <= angle_d;
                acc_q   <= acc_d;
                dir_q   <= dir_d;
            end
        end

        assign oAngle[n*ANGLE_W +: ANGLE_W] = angle_q;
        assign oDir[n]                      = dir_q;
        assign oAtLimit[n]                  = at_lim;
    end

endmodule

// File: tb/tb_servo_angle_ctrl.sv
module tb_servo_angle_ctrl;

    logic        Clk;
    logic        Rst_n;
    logic        iKey;
    logic [1:0]  iSel;
    logic [3:0]  iRate;
    logic [1:0]  iMode;
    logic [31:0] oAngle;
    logic [3:0]  oDir;
    logic [3:0]  oAtLimit;
    logic        oKeyEvt;
    logic [23:0] oAngle3;
    logic [2:0]  oDir3;
    logic [2:0]  oAtLimit3;
    logic        oKeyEvt3;

    int n_tests = 0;
    int n_fail  = 0;

    servo_angle_ctrl #(.NUM_CH(4), .ACC_W(6), .DEB_CYCLES(4)) dut (
        .Clk(Clk), .Rst_n(Rst_n), .iKey(iKey), .iSel(iSel), .iRate(iRate), .iMode(iMode),
        .oAngle(oAngle), .oDir(oDir), .oAtLimit(oAtLimit), .oKeyEvt(oKeyEvt)
    );

    servo_angle_ctrl #(.NUM_CH(3), .ACC_W(6), .DEB_CYCLES(4)) dut3 (
        .Clk(Clk), .Rst_n(Rst_n), .iKey(iKey), .iSel(iSel), .iRate(iRate), .iMode(iMode),
        .oAngle(oAngle3), .oDir(oDir3), .oAtLimit(oAtLimit3), .oKeyEvt(oKeyEvt3)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic [1:0] mode;
        logic [3:0] rate;
        int         cycles;
        logic [7:0] ang;
        logic       dir;
        logic       lim;
    } vec_t;

    vec_t tbl[14];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    function automatic logic [7:0] ang(input int ch);
        return oAngle[ch*8 +: 8];
    endfunction

    task automatic do_reset();
        iMode = 2'd0;
        iRate = 4'd0;
        iKey  = 1'b0;
        iSel  = 2'd0;
        Rst_n = 1'b0;
        @(posedge Clk);
        #1;
        Rst_n = 1'b1;
    endtask

    // Hold the key high for len cycles, counting event pulses on both instances.
    task automatic key_press(input logic [1:0] s, input int len, output int pulses, output int pulses3);
        iSel    = s;
        iKey    = 1'b1;
        pulses  = 0;
        pulses3 = 0;
        for (int k = 1; k <= len; k++) begin
            @(posedge Clk);
            #1;
            if (oKeyEvt)  pulses++;
            if (oKeyEvt3) pulses3++;
        end
    endtask

    initial begin
        int p, p3, first, gl, bad, mx;
        logic [3:0]  d7, d8;
        logic [31:0] snap_a;
        logic [3:0]  snap_d;

        //           mode  rate  cyc  ang  dir  lim
        tbl[0]  = '{2'd0, 4'd4,   50, 8'd60,  1'b0, 1'b0};
        tbl[1]  = '{2'd1, 4'd4,    9, 8'd59,  1'b0, 1'b0};
        tbl[2]  = '{2'd1, 4'd4,    8, 8'd60,  1'b0, 1'b0};
        tbl[3]  = '{2'd1, 4'd4,   90, 8'd50,  1'b0, 1'b0};
        tbl[4]  = '{2'd1, 4'd8,   50, 8'd50,  1'b0, 1'b0};
        tbl[5]  = '{2'd1, 4'd15,  40, 8'd50,  1'b0, 1'b0};
        tbl[6]  = '{2'd3, 4'd15,  40, 8'd60,  1'b0, 1'b0};
        tbl[7]  = '{2'd1, 4'd0,   40, 8'd60,  1'b0, 1'b0};
        tbl[8]  = '{2'd1, 4'd8,  400, 8'd0,   1'b0, 1'b1};
        tbl[9]  = '{2'd2, 4'd8,  304, 8'd0,   1'b0, 1'b1};
        tbl[10] = '{2'd2, 4'd8,  305, 8'd0,   1'b1, 1'b0};
        tbl[11] = '{2'd2, 4'd8,  350, 8'd9,   1'b1, 1'b0};
        tbl[12] = '{2'd1, 4'd1,   66, 8'd58,  1'b0, 1'b0};
        tbl[13] = '{2'd2, 4'd0,  100, 8'd60,  1'b0, 1'b0};

        // ---------------- reset / idle ----------------
        do_reset();
        check("rst_angle", oAngle, {4{8'd60}});
        check("rst_dir", oDir, 4'b0000);
        check("rst_evt", oKeyEvt, 1'b0);
        bad = 0;
        p   = 0;
        for (int k = 0; k < 200; k++) begin
            @(posedge Clk);
            #1;
            if (oAngle !== {4{8'd60}}) bad++;
            if (oKeyEvt) p++;
        end
        check("idle_angle_changes", bad, 0);
        check("idle_evt_pulses", p, 0);

        // ---------------- debounce ----------------
        iSel = 2'd2;
        iKey = 1'b1;
        gl   = 0;
        for (int k = 1; k <= 15; k++) begin
            @(posedge Clk);
            #1;
            if (k == 3) iKey = 1'b0;
            if (oKeyEvt) gl++;
        end
        check("glitch_evt", gl, 0);
        iKey  = 1'b1;
        p     = 0;
        first = -1;
        d7    = 4'hx;
        d8    = 4'hx;
        for (int k = 1; k <= 20; k++) begin
            @(posedge Clk);
            #1;
            if (oKeyEvt) begin
                p++;
                first = k;
            end
            if (k == 7) d7 = oDir;
            if (k == 8) d8 = oDir;
        end
        check("deb_evt_count", p, 1);
        check("deb_evt_cycle", first, 7);
        check("deb_dir_in_evt_cycle", d7, 4'b0000);
        check("deb_dir_after", d8, 4'b0100);
        check("deb_dir3_after", oDir3, 3'b100);
        iKey = 1'b0;
        p    = 0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge Clk);
            #1;
            if (oKeyEvt) p++;
        end
        check("release_evt", p, 0);
        check("release_dir", oDir, 4'b0100);

        // ---------------- ramp ----------------
        iMode = 2'd1;
        iRate = 4'd4;
        mx    = 0;
        for (int k = 1; k <= 1130; k++) begin
            @(posedge Clk);
            #1;
            if (ang(2) > mx) mx = ang(2);
            if (k == 8)    check("ramp_ch2_c8", ang(2), 8'd60);
            if (k == 9)    check("ramp_ch2_c9", ang(2), 8'd61);
            if (k == 18)   check("ramp_ch2_c18", ang(2), 8'd62);
            if (k == 18)   check("ramp_ch0_c18", ang(0), 8'd58);
            if (k == 531)  check("ramp_ch0_c531", ang(0), 8'd1);
            if (k == 540)  check("ramp_ch0_c540", ang(0), 8'd0);
            if (k == 1071) check("ramp_ch2_c1071", ang(2), 8'd179);
            if (k == 1080) check("ramp_ch2_c1080", ang(2), 8'd180);
        end
        check("ramp_ch2_max", mx, 180);
        check("ramp_final_angle", oAngle, {8'd0, 8'd180, 8'd0, 8'd0});
        check("ramp_final_lim", oAtLimit, 4'hF);
        check("ramp_final_dir", oDir, 4'b0100);

        // ---------------- sweep ----------------
        iMode = 2'd2;
        iRate = 4'd8;
        bad   = 0;
        for (int k = 1; k <= 2000; k++) begin
            @(posedge Clk);
            #1;
            for (int c = 0; c < 4; c++) if (ang(c) > 8'd180) bad++;
            if (k == 4)   check("sweep_ch2_c4", {oDir[2], ang(2)}, {1'b1, 8'd180});
            if (k == 5)   check("sweep_ch2_c5", {oDir[2], ang(2)}, {1'b0, 8'd180});
            if (k == 10)  check("sweep_ch2_c10", ang(2), 8'd179);
            if (k == 10)  check("sweep_ch0_c10", {oDir[0], ang(0)}, {1'b1, 8'd1});
            if (k == 905) check("sweep_ch2_c905", ang(2), 8'd0);
            if (k == 905) check("sweep_ch0_c905", ang(0), 8'd180);
        end
        check("sweep_out_of_range", bad, 0);
        iRate = 4'd0;
        repeat (2) @(posedge Clk);
        #1;
        snap_a = oAngle;
        snap_d = oDir;
        repeat (100) @(posedge Clk);
        #1;
        check("sweep_rate0_angle", oAngle, snap_a);
        check("sweep_rate0_dir", oDir, snap_d);

        // ---------------- collision: key toggle + sweep reversal on ch1 ----------------
        do_reset();
        iMode = 2'd2;
        iRate = 4'd8;
        repeat (297) @(posedge Clk);
        #1;
        iSel = 2'd1;
        iKey = 1'b1;
        for (int k = 1; k <= 13; k++) begin
            @(posedge Clk);
            #1;
            if (k == 7) begin
                check("coll_evt_align", oKeyEvt, 1'b1);
                check("coll_pre", {oDir[1], ang(1)}, {1'b0, 8'd0});
            end
            if (k == 8) begin
                check("coll_angle", ang(1), 8'd0);
                check("coll_dir", oDir[1], 1'b1);
                check("coll_dir3", oDir3[1], 1'b1);
            end
            if (k == 13) check("coll_resume", ang(1), 8'd1);
        end
        iKey = 1'b0;

        // ---------------- out-of-range iSel on the 3-channel instance ----------------
        do_reset();
        key_press(2'd3, 20, p, p3);
        iKey = 1'b0;
        check("sel3_evt3", p3, 1);
        check("sel3_dir3", oDir3, 3'b000);
        check("sel3_dir4", oDir, 4'b1000);

        // ---------------- reset mid-ramp and mid-debounce ----------------
        do_reset();
        key_press(2'd0, 20, p, p3);
        iKey = 1'b0;
        repeat (20) @(posedge Clk);
        #1;
        check("mid_dir_before", oDir, 4'b0001);
        iMode = 2'd1;
        iRate = 4'd4;
        for (int k = 1; k <= 13; k++) begin
            @(posedge Clk);
            #1;
            if (k == 10) iKey = 1'b1;
        end
        check("mid_pre_angle", oAngle, {8'd59, 8'd59, 8'd59, 8'd61});
        Rst_n = 1'b0;
        iKey  = 1'b0;
        #1;
        check("mid_rst_angle", oAngle, {4{8'd60}});
        check("mid_rst_dir", oDir, 4'b0000);
        @(posedge Clk);
        #1;
        Rst_n = 1'b1;
        p     = 0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge Clk);
            #1;
            if (oKeyEvt) p++;
            if (k == 8) check("mid_after_c8", ang(0), 8'd60);
            if (k == 9) check("mid_after_c9", oAngle, {4{8'd59}});
        end
        check("mid_after_evt", p, 0);

        // ---------------- table-driven mode/rate vectors ----------------
        for (int i = 0; i < 14; i++) begin
            do_reset();
            iMode = tbl[i].mode;
            iRate = tbl[i].rate;
            repeat (tbl[i].cycles) @(posedge Clk);
            #1;
            check($sformatf("tbl%0d_angle", i), oAngle, {4{tbl[i].ang}});
            check($sformatf("tbl%0d_dir", i), oDir, {4{tbl[i].dir}});
            check($sformatf("tbl%0d_lim", i), oAtLimit, {4{tbl[i].lim}});
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/servo_angle_ctrl.md
Name: servo_angle_ctrl

Overview:
- Multi-channel servo angle generator; each channel holds an angle that ramps at a programmable rate between MIN_ANGLE and MAX_ANGLE.
- A debounced push-button toggles the direction of the channel chosen by iSel.
- A global mode selects hold, one-shot ramp to the limit, or continuous sweep.
- Output angles feed the per-channel PWM generators downstream.

Parameters:
- NUM_CH, 4: number of servo channels (1..16).
- ANGLE_W, 8: angle width in bits.
- MIN_ANGLE, 0: lower angle limit.
- MAX_ANGLE, 180: upper angle limit (MIN_ANGLE < MAX_ANGLE < 2^ANGLE_W).
- INIT_ANGLE, 60: reset angle for every channel; must lie in [MIN_ANGLE, MAX_ANGLE].
- STEP, 1: angle change per rate tick.
- ACC_W, 22: rate accumulator width; a tick fires when the accumulator MSB is set.
- RATE_W, 4: width of iRate.
- DEB_CYCLES, 250000: consecutive stable cycles required to accept a key level change.

Ports:
- Clk, input, 1: system clock.
- Rst_n, input, 1: asynchronous active-low reset.
- iKey, input, 1: raw push-button, asynchronous to Clk, active-high.
- iSel, input, max(1,$clog2(NUM_CH)): channel whose direction the key toggles.
- iRate, input, RATE_W: accumulator increment per cycle; 0 means no motion.
- iMode, input, 2: 0 = HOLD, 1 = RAMP, 2 = SWEEP, 3 = treated as HOLD.
- oAngle, output, NUM_CH*ANGLE_W: packed angles; channel n occupies bits [n*ANGLE_W +: ANGLE_W].
- oDir, output, NUM_CH: per-channel direction; 1 = increasing, 0 = decreasing.
- oAtLimit, output, NUM_CH: channel sits at the limit it is heading toward.
- oKeyEvt, output, 1: one-cycle pulse per accepted key press.

Behaviour:
- Reset, asynchronous, Rst_n low:
  - every oAngle channel = INIT_ANGLE; oDir = 0.
  - all accumulators = 0; sync and debounce state = 0; oKeyEvt = 0.
- Key path:
  - iKey passes through a 2-FF synchroniser.
  - The debounced level takes the synced value after that value has differed from the debounced level for DEB_CYCLES consecutive cycles. Any mismatch break resets the count.
  - A debounced 0->1 transition asserts oKeyEvt for exactly the next cycle. Release generates no event.
- Key event:
  - In the oKeyEvt cycle, iSel is sampled and oDir[iSel] toggles in the following cycle.
  - iSel >= NUM_CH: the event is ignored and no oDir bit changes; oKeyEvt still pulses.
  - Direction toggles are accepted in every mode, including HOLD.
- Rate accumulator, per channel, updated each cycle:
  - HOLD: accumulator and angle are held.
  - RAMP/SWEEP with MSB = 0: acc <= acc + iRate.
  - RAMP/SWEEP with MSB = 1: this is a tick. acc <= 0 (no remainder kept) and the step rule below applies.
  - Tick period from acc = 0 with constant iRate r: ceil(2^(ACC_W-1)/r) + 1 cycles.
  - A mode change takes effect the next cycle; the accumulator is not cleared.
- Step rule on a tick:
  - oDir = 1: angle <= min(angle + STEP, MAX_ANGLE).
  - oDir = 0: angle <= max(angle - STEP, MIN_ANGLE).
  - Arithmetic uses ANGLE_W+1 bits, so no wrap-around ever occurs.
  - RAMP at the limit: the angle is held and the accumulator is held at 0 while oAtLimit = 1.
  - SWEEP at the limit: the tick inverts the direction with no angle change that tick; motion resumes the opposite way on the next tick.
- Simultaneous key toggle and tick on the same channel:
  - The step uses the pre-toggle direction.
  - Next direction = ~dir. A sweep reversal in the same cycle is suppressed, so the net result is a single inversion.
- oAtLimit[n] is combinational from registers: (dir & angle == MAX_ANGLE) | (~dir & angle == MIN_ANGLE).
- Reset asserted mid-ramp or mid-debounce: all state returns to reset values immediately.

Test Plan:
All scenarios use ACC_W=6, DEB_CYCLES=4, NUM_CH=4.
- Reset/idle: release reset with iMode=0 -> all angles = 60, oDir = 0, oKeyEvt never pulses, angles constant for 200 cycles.
- Debounce: glitch iKey high for 3 cycles, then hold high 20 cycles, iSel=2 -> exactly one oKeyEvt, 2+4+1 cycles after the stable edge; only oDir[2] becomes 1. Releasing iKey -> no pulse.
- Ramp timing: iMode=1, iRate=4, oDir[2]=1 -> ch2 increments by 1 every 9 cycles and stops at 180 with oAtLimit[2]=1. Channels 0, 1 and 3 decrement to 0 and stop there.
- Sweep: iMode=2, iRate=8 (5-cycle ticks), MIN=0, MAX=180 -> the channel reaches 180, holds one tick, oDir flips, then it descends. No value ever exceeds 180 or drops below 0. Repeat with iRate=0 -> no motion.
- Collision: arrange a key event and a sweep reversal tick on ch1 in the same cycle -> the angle is unchanged and oDir[1] inverts exactly once. With iSel=3 and NUM_CH=3 -> no oDir change.
- Reset mid-operation: assert Rst_n low for one cycle mid-ramp and mid-debounce -> all angles = 60, oDir = 0 and the accumulators restart, so the next tick arrives a full 9 cycles after release.
